// File: rtl/exu_div_cl_ctl_pkg.sv
// Shared types and constants for the constant-latency EXU divider.
package exu_div_cl_ctl_pkg;

    localparam int unsigned DIV_CL_WIDTH   = 32;
    localparam int unsigned DIV_CL_LATENCY = 36;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        PAD,
        DONE
    } div_cl_state_t;

endpackage

// File: rtl/exu_div_cl_core.sv
// Unsigned restoring shift/subtract divider, one quotient bit per cycle.
module exu_div_cl_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int unsigned SW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] b_q;
    logic [SW-1:0]    step_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Borrow in bit WIDTH means the trial subtraction must be discarded.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            b_q    <= '0;
            step_q <= '0;
            done   <= 1'b0;
        end else if (start) begin
            quo_q  <= a;
            rem_q  <= '0;
            b_q    <= b;
            step_q <= SW'(WIDTH);
            done   <= 1'b0;
        end else if (step_q != '0) begin
            rem_q  <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_q  <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            step_q <= step_q - SW'(1);
            done   <= (step_q == SW'(1));
        end else begin
            done   <= 1'b0;
        end
    end

    assign q = quo_q;
    assign r = rem_q;

endmodule

// File: rtl/exu_div_cl_ctl.sv
// EXU integer divider with run-time selectable constant or native latency.
module exu_div_cl_ctl
    import exu_div_cl_ctl_pkg::*;
#(
    parameter int unsigned WIDTH   = DIV_CL_WIDTH,
    parameter int unsigned LATENCY = DIV_CL_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             const_lat_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  div_pkt_t         dp,
    input  logic             flush_lower,
    output logic             valid_ff_e1,
    output logic             div_stall,
    output logic             finish,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_CALC = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    if (LATENCY < WIDTH + 2) begin : g_lat_chk
        $error("exu_div_cl_ctl: LATENCY must be at least WIDTH+2");
    end

    div_cl_state_t    state_q, state_nx;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, res_q, out_q;
    logic             unsign_q, rem_sel_q, const_q, neg_q_q, neg_r_q;
    logic             accept, special_c, div0_c, ovf_c;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] core_q, core_r, fix_q, fix_r;
    logic             core_done;

    assign mag_a = (~dp.unsign & dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_b = (~dp.unsign & divisor[WIDTH-1])  ? -divisor  : divisor;

    // Special operands are only resolved in the first busy cycle.
    assign div0_c    = (dvs_q == '0);
    assign ovf_c     = ~unsign_q & (dvd_q == MIN_INT) & (dvs_q == '1);
    assign special_c = (state_q == CALC) & (cnt_q == CNT_W'(1)) & (div0_c | ovf_c);

    assign fix_q = neg_q_q ? -core_q : core_q;
    assign fix_r = neg_r_q ? -core_r : core_r;

    exu_div_cl_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .a     (mag_a),
        .b     (mag_b),
        .q     (core_q),
        .r     (core_r),
        .done  (core_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                if (special_c)
                    state_nx = (const_q && cnt_q != CNT_LAST) ? PAD : DONE;
                else if (cnt_q == CNT_CALC)
                    state_nx = FIX;
            end
            FIX:  state_nx = (const_q && cnt_q != CNT_LAST) ? PAD : DONE;
            PAD:  if (cnt_q == CNT_LAST) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush_lower && state_q != IDLE) state_nx = IDLE;
    end

    // A flushed finish cycle must leave the visible result untouched.
    always_comb begin
        accept    = dp.valid & ~flush_lower & (state_q == IDLE);
        div_stall = (state_q != IDLE);
        finish    = (state_q == DONE) & ~flush_lower;
        out       = finish ? res_q : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            valid_ff_e1 <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            unsign_q    <= 1'b0;
            rem_sel_q   <= 1'b0;
            const_q     <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            res_q       <= '0;
            out_q       <= '0;
        end else begin
            valid_ff_e1 <= dp.valid & ~flush_lower;
            if (state_nx == IDLE)     cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (accept) begin
                dvd_q     <= dividend;
                dvs_q     <= divisor;
                unsign_q  <= dp.unsign;
                rem_sel_q <= dp.rem;
                const_q   <= const_lat_en;
                neg_q_q   <= ~dp.unsign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r_q   <= ~dp.unsign & dividend[WIDTH-1];
            end
            if (special_c) begin
                if (div0_c) res_q <= rem_sel_q ? dvd_q : '1;
                else        res_q <= rem_sel_q ? '0 : MIN_INT;
            end else if (state_q == FIX && core_done) begin
                res_q <= rem_sel_q ? fix_r : fix_q;
            end
            if (finish) out_q <= res_q;
        end
    end

endmodule

// File: tb/tb_exu_div_cl_ctl.sv
// Directed bench for exu_div_cl_ctl: latency, results, specials, flush, reset.
module tb_exu_div_cl_ctl;
    import exu_div_cl_ctl_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 36;

    logic         clk = 1'b0;
    logic         rst;
    logic         const_lat_en;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    div_pkt_t     dp;
    logic         flush_lower;
    logic         valid_ff_e1;
    logic         div_stall;
    logic         finish;
    logic [W-1:0] out;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_out;
    logic         saw_finish;

    always #5 clk = ~clk;

    exu_div_cl_ctl #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .const_lat_en (const_lat_en),
        .dividend     (dividend),
        .divisor      (divisor),
        .dp           (dp),
        .flush_lower  (flush_lower),
        .valid_ff_e1  (valid_ff_e1),
        .div_stall    (div_stall),
        .finish       (finish),
        .out          (out)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request in cycle 0; returns in cycle 1 with operands scrambled.
    task automatic issue(input logic cl, input logic uns, input logic rm,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        const_lat_en = cl;
        dividend     = a;
        divisor      = b;
        dp           = '{valid: 1'b1, unsign: uns, rem: rm};
        step();
        dp.valid     = 1'b0;
        const_lat_en = ~cl;
        dividend     = 32'h1234_5678;
        divisor      = 32'h0000_0003;
    endtask

    task automatic find_finish(input int from, input int exp_n,
                               input logic [W-1:0] exp_out, input string tag);
        int n;
        n = 0;
        for (int k = from; k <= LAT + 10; k++) begin
            if (finish) begin
                n = k;
                break;
            end
            step();
        end
        check({tag, " finish_cycle"}, W'(n), W'(exp_n));
        check({tag, " out"}, out, exp_out);
        last_out = exp_out;
        step();
        check({tag, " stall_after"}, W'(div_stall), W'(0));
        check({tag, " finish_after"}, W'(finish), W'(0));
        check({tag, " out_held"}, out, last_out);
    endtask

    task automatic run_div(input logic cl, input logic uns, input logic rm,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_n, input logic [W-1:0] exp_out, input string tag);
        issue(cl, uns, rm, a, b);
        check({tag, " stall_c1"}, W'(div_stall), W'(1));
        check({tag, " valid_e1"}, W'(valid_ff_e1), W'(1));
        check({tag, " out_c1"}, out, last_out);
        find_finish(1, exp_n, exp_out, tag);
    endtask

    initial begin
        rst          = 1'b1;
        const_lat_en = 1'b0;
        dividend     = '0;
        divisor      = '0;
        dp           = '{valid: 1'b0, unsign: 1'b0, rem: 1'b0};
        flush_lower  = 1'b0;
        last_out     = '0;
        step();
        step();
        check("rst valid_ff_e1", W'(valid_ff_e1), W'(0));
        check("rst div_stall", W'(div_stall), W'(0));
        check("rst finish", W'(finish), W'(0));
        check("rst out", out, '0);
        rst = 1'b0;
        step();

        run_div(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 36, 32'd14, "c_s_div");
        run_div(1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 36, 32'd2, "c_s_rem");
        run_div(1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 36, 32'hFFFF_FFFF, "c_div0");
        run_div(1'b1, 1'b1, 1'b1, 32'd5, 32'd0, 36, 32'd5, "c_div0_rem");
        run_div(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, "n_div0");
        run_div(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 36, 32'h8000_0000, "c_ovf");
        run_div(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 36, 32'h0, "c_ovf_rem");
        run_div(1'b0, 1'b0, 1'b0, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2, "n_neg_div");
        run_div(1'b0, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFFE, "n_neg_rem");
        run_div(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 34, 32'h0FFF_FFFF, "n_u_big");

        // Flush in cycle 10, then a new divide accepted in cycle 11.
        issue(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        saw_finish = 1'b0;
        for (int c = 1; c < 10; c++) begin
            saw_finish = saw_finish | finish;
            step();
        end
        flush_lower = 1'b1;
        #1;
        saw_finish = saw_finish | finish;
        step();
        flush_lower = 1'b0;
        check("flush no_finish", W'(saw_finish), W'(0));
        check("flush stall_c11", W'(div_stall), W'(0));
        check("flush valid_e1", W'(valid_ff_e1), W'(0));
        check("flush out_kept", out, last_out);
        run_div(1'b1, 1'b1, 1'b0, 32'd9, 32'd3, 36, 32'd3, "after_flush");

        // Stray dp.valid in cycle 15 while busy must not disturb the divide.
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FF9C, 32'd7);
        for (int c = 1; c < 15; c++) step();
        dividend = 32'd1;
        divisor  = 32'd1;
        dp       = '{valid: 1'b1, unsign: 1'b1, rem: 1'b1};
        step();
        dp.valid = 1'b0;
        check("busy valid_e1", W'(valid_ff_e1), W'(1));
        check("busy stall", W'(div_stall), W'(1));
        find_finish(16, 36, 32'hFFFF_FFF2, "busy_ignore");

        // Reset in cycle 20 clears everything without a finish.
        issue(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
        saw_finish = 1'b0;
        for (int c = 1; c < 20; c++) begin
            saw_finish = saw_finish | finish;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst no_finish", W'(saw_finish | finish), W'(0));
        check("midrst stall", W'(div_stall), W'(0));
        check("midrst valid_e1", W'(valid_ff_e1), W'(0));
        check("midrst out", out, '0);
        last_out = '0;
        run_div(1'b0, 1'b1, 1'b1, 32'd7, 32'd2, 34, 32'd1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
